// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter: FSM states, default widths
// and the rotated-priority winner search.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDRESP = 2'd2
    } state_t;

    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 2;

    // Scans from last_gnt+num_req down to last_gnt+1 so the nearest requester
    // above last_gnt is written last and wins; returns 0 when nothing is valid.
    function automatic int rr_winner(input logic [31:0] req, input int last_gnt,
                                     input int num_req);
        int idx;
        rr_winner = 0;
        for (int i = num_req; i >= 1; i--) begin
            idx = (last_gnt + i) % num_req;
            if (req[idx]) rr_winner = idx;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational requester selection: round-robin by default, fixed lowest-index
// priority when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   winner
);

    int win_i;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_gnt;
    assign unused_last_gnt = ^last_gnt;

    always_comb begin
        win_i = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) win_i = i;
        end
    end
`else
    logic [31:0] req_ext;

    always_comb begin
        req_ext = '0;
        req_ext[NUM_REQ-1:0] = req;
        win_i = rr_winner(req_ext, int'(last_gnt), NUM_REQ);
    end
`endif

    always_comb begin
        winner = IDX_W'(win_i);
        gnt    = '0;
        if (|req) gnt[winner] = 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises read/write requests from NUM_REQ requesters onto one single-port
// synchronous memory; MEM_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
//
//  state  | meaning
//  IDLE   | arbitrate; winner's request latched onto the memory port on accept
//  ISSUE  | one cycle with mem_wr_en or mem_rd_en high
//  RDRESP | memory read data returned with rsp_valid to the originator
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_wr_en,
    output logic                         mem_rd_en,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic                         busy
);

    state_t               state;
    logic [IDX_W-1:0]     last_gnt;
    logic [IDX_W-1:0]     id_q;
    logic [NUM_REQ-1:0]   gnt;
    logic [IDX_W-1:0]     winner;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                 sel_wr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req_valid),
        .last_gnt (last_gnt),
        .gnt      (gnt),
        .winner   (winner)
    );

    assign sel_addr  = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_wr    = req_wr[winner];

    assign req_ready = (state == IDLE && !reset) ? gnt : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            last_gnt  <= IDX_W'(NUM_REQ - 1);
            id_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_wr_en <= sel_wr;
                        mem_rd_en <= !sel_wr;
                        id_q      <= winner;
                        last_gnt  <= winner;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_wr_en <= 1'b0;
                    mem_rd_en <= 1'b0;
                    state     <= mem_rd_en ? RDRESP : IDLE;
                end
                RDRESP:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory output is already registered, so the response is a pass-through.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (state == RDRESP && !reset) begin
            rsp_valid[id_q] = 1'b1;
            rsp_rdata       = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory
// (contents reset to 8'hFF, one-cycle registered read).
module tb_mem_arbiter;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_wr;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_wr_en;
    logic            mem_rd_en;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            busy;

    logic [DW-1:0]   mem [0:(1<<AW)-1];

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hFF;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[id]          = 1'b1;
        req_wr[id]             = wr;
        req_addr[id*AW +: AW]  = a;
        req_wdata[id*DW +: DW] = d;
    endtask

    task automatic wait_ready(input int id);
        int n = 0;
        #1;
        while (!req_ready[id] && n < 20) begin
            tick;
            n++;
        end
        check_val("ready_wait", 32'(req_ready[id]), 32'd1);
    endtask

    task automatic do_write(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_req(id, 1'b1, a, d);
        wait_ready(id);
        tick;
        req_valid[id] = 1'b0;
        #1;
        check_val("wr_strobe", {mem_wr_en, mem_rd_en}, 2'b10);
        check_val("wr_addr", 32'(mem_addr), 32'(a));
        check_val("wr_data", 32'(mem_wdata), 32'(d));
        tick;
        check_val("wr_done", {mem_wr_en, busy}, 2'b00);
    endtask

    task automatic do_read(input int id, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        set_req(id, 1'b0, a, '0);
        wait_ready(id);
        tick;
        req_valid[id] = 1'b0;
        #1;
        check_val("rd_strobe", {mem_wr_en, mem_rd_en}, 2'b01);
        check_val("rd_addr", 32'(mem_addr), 32'(a));
        check_val("rd_rsp_early", 32'(rsp_valid), 32'd0);
        tick;
        check_val("rd_rsp_valid", 32'(rsp_valid), 32'(1 << id));
        check_val("rd_rsp_data", 32'(rsp_rdata), 32'(exp));
        tick;
        check_val("rd_rsp_end", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) tick;

        // reset state, and a request pending during reset is not taken
        set_req(0, 1'b0, 2'd2, 8'h00);
        #1;
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_outs", {busy, mem_wr_en, mem_rd_en, mem_addr, mem_wdata}, '0);
        check_val("rst_rsp", {rsp_valid, rsp_rdata}, '0);
        tick;
        check_val("rst_hold", 32'(busy), 32'd0);
        reset = 1'b0;

        // first read: rsp two cycles after accept, memory reset value
        do_read(0, 2'd2, 8'hFF);

        // write from 1 then read same address from 0
        do_write(1, 2'd1, 8'hA5);
        do_read(0, 2'd1, 8'hA5);

        // back-to-back writes, one accept every two cycles
        set_req(0, 1'b1, 2'd0, 8'h10);
        #1;
        for (int i = 0; i < 4; i++) begin
            check_val("bb_ready", 32'(req_ready), 32'b01);
            tick;
            if (i < 3) set_req(0, 1'b1, AW'(i + 1), DW'(8'h11 + i));
            else req_valid[0] = 1'b0;
            #1;
            check_val("bb_issue", {mem_wr_en, 6'(mem_addr), mem_wdata, req_ready},
                      {1'b1, 6'(i), DW'(8'h10 + i), 2'b00});
            tick;
            #1;
        end
        for (int i = 0; i < 4; i++) do_read(0, AW'(i), DW'(8'h10 + i));

        // leave last_gnt at 1 so requester 0 is next in rotation
        do_write(1, 2'd3, 8'h3C);

`ifndef MEM_ARB_FIXED_PRIO_EN
        set_req(0, 1'b0, 2'd0, 8'h00);
        set_req(1, 1'b0, 2'd3, 8'h00);
        #1;
        for (int k = 0; k < 4; k++) begin
            check_val("rr_ready", 32'(req_ready), 32'(1 << (k % 2)));
            tick;
            check_val("rr_issue", {req_ready, mem_rd_en, busy}, 4'b0011);
            check_val("rr_addr", 32'(mem_addr), (k % 2 == 0) ? 32'd0 : 32'd3);
            tick;
            check_val("rr_rsp", 32'(rsp_valid), 32'(1 << (k % 2)));
            check_val("rr_data", 32'(rsp_rdata), (k % 2 == 0) ? 32'h10 : 32'h3C);
            tick;
            #1;
        end
`else
        set_req(0, 1'b0, 2'd0, 8'h00);
        set_req(1, 1'b0, 2'd3, 8'h00);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val("fp_ready", 32'(req_ready), 32'b01);
            tick;
            tick;
            check_val("fp_rsp", 32'(rsp_valid), 32'b01);
            tick;
            #1;
        end
        req_valid[0] = 1'b0;
        #1;
        check_val("fp_ready1", 32'(req_ready), 32'b10);
        tick;
        tick;
        check_val("fp_rsp1", {rsp_valid, rsp_rdata}, {2'b10, 8'h3C});
        tick;
        // restore last_gnt=1 ahead of the reset test, same as the default build
        set_req(0, 1'b0, 2'd0, 8'h00);
        #1;
`endif

        // both valid, requester 0 wins, reset during ISSUE drops the response
        #1;
        check_val("rst_pre_ready", 32'(req_ready), 32'b01);
        tick;
        check_val("rst_pre_issue", 32'(mem_rd_en), 32'd1);
        reset = 1'b1;
        #1;
        check_val("rst_mid_ready", 32'(req_ready), 32'd0);
        tick;
        reset = 1'b0;
        #1;
        check_val("rst_mid_state", {busy, mem_wr_en, mem_rd_en, rsp_valid}, '0);
        check_val("rst_mid_win", 32'(req_ready), 32'b01);
        tick;
        req_valid = '0;
        #1;
        check_val("rst_post_issue", {mem_rd_en, 6'(mem_addr)}, {1'b1, 6'd0});
        tick;
        check_val("rst_post_rsp", {rsp_valid, rsp_rdata}, {2'b01, 8'h10});
        tick;
        check_val("final_idle", {busy, rsp_valid}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
